// File: rtl/very_half_sam_core.sv
// Very Half SAM: 8-bit accumulator CPU that fetches from an external
// synchronous memory over a shared tristate data bus, with a console display mux.
module very_half_sam_core (
    input  logic       clk,
    input  logic       rst,
    output logic       En,
    output logic       Rw,
    output logic [7:0] Address_Bus,
    inout  wire  [7:0] Data_Bus,
    input  logic       pause,
    input  logic [1:0] regSelect,
    output logic [7:0] dispReg
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_RD_X,
        S_CAP_X,
        S_RD_IND,
        S_CAP_IND,
        S_WR_X,
        S_WR_IND,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_MISC   = 4'h0,
        OP_BR     = 4'h1,
        OP_BRZ    = 4'h2,
        OP_BRP    = 4'h3,
        OP_BRN    = 4'h4,
        OP_BRIND  = 4'h5,
        OP_CLOAD  = 4'h6,
        OP_DLOAD  = 4'h7,
        OP_ILOAD  = 4'h8,
        OP_DSTORE = 4'h9,
        OP_ISTORE = 4'hA,
        OP_ADD    = 4'hB,
        OP_AND    = 4'hC
    } opcode_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] ireg_q, ireg_d;
    logic [7:0] iar_q, iar_d;

    logic       mem_en;
    logic       mem_rw;
    logic [7:0] mem_addr;

    opcode_t    dec_op;
    opcode_t    exe_op;
    logic [7:0] dec_sx;
    logic       take_branch;

    // In DECODE the instruction is still on the bus; IREG holds it afterwards.
    assign dec_op = opcode_t'(Data_Bus[7:4]);
    assign dec_sx = {{4{Data_Bus[3]}}, Data_Bus[3:0]};
    assign exe_op = opcode_t'(ireg_q[7:4]);

    always_comb begin
        take_branch = 1'b0;
        case (dec_op)
            OP_BR:   take_branch = 1'b1;
            OP_BRZ:  take_branch = (acc_q == 8'h00);
            OP_BRP:  take_branch = !acc_q[7] && (acc_q != 8'h00);
            OP_BRN:  take_branch = acc_q[7];
            default: take_branch = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        acc_d    = acc_q;
        ireg_d   = ireg_q;
        iar_d    = iar_q;
        mem_en   = 1'b0;
        mem_rw   = 1'b1;
        mem_addr = '0;

        case (state_q)
            S_FETCH: begin
                if (!pause) begin
                    mem_en   = 1'b1;
                    mem_addr = pc_q;
                    pc_d     = pc_q + 8'd1;
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                ireg_d  = Data_Bus;
                state_d = S_FETCH;
                case (dec_op)
                    OP_MISC: begin
                        if (Data_Bus[3:0] == 4'h1) begin
                            acc_d = ~acc_q + 8'd1;
                        end else begin
                            state_d = S_HALT;
                        end
                    end
                    OP_BR, OP_BRZ, OP_BRP, OP_BRN: begin
                        if (take_branch) begin
                            pc_d = pc_q + dec_sx;
                        end
                    end
                    OP_CLOAD: acc_d = dec_sx;
                    OP_BRIND, OP_DLOAD, OP_ILOAD, OP_ISTORE, OP_ADD, OP_AND:
                        state_d = S_RD_X;
                    OP_DSTORE: state_d = S_WR_X;
                    default:   state_d = S_HALT;
                endcase
            end

            S_RD_X: begin
                mem_en   = 1'b1;
                mem_addr = {4'h0, ireg_q[3:0]};
                state_d  = S_CAP_X;
            end

            S_CAP_X: begin
                state_d = S_FETCH;
                case (exe_op)
                    OP_BRIND: pc_d = Data_Bus;
                    OP_DLOAD: acc_d = Data_Bus;
                    OP_ADD:   acc_d = acc_q + Data_Bus;
                    OP_AND:   acc_d = acc_q & Data_Bus;
                    OP_ILOAD: begin
                        iar_d   = Data_Bus;
                        state_d = S_RD_IND;
                    end
                    OP_ISTORE: begin
                        iar_d   = Data_Bus;
                        state_d = S_WR_IND;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_RD_IND: begin
                mem_en   = 1'b1;
                mem_addr = iar_q;
                state_d  = S_CAP_IND;
            end

            S_CAP_IND: begin
                acc_d   = Data_Bus;
                state_d = S_FETCH;
            end

            S_WR_X: begin
                mem_en   = 1'b1;
                mem_rw   = 1'b0;
                mem_addr = {4'h0, ireg_q[3:0]};
                state_d  = S_FETCH;
            end

            S_WR_IND: begin
                mem_en   = 1'b1;
                mem_rw   = 1'b0;
                mem_addr = iar_q;
                state_d  = S_FETCH;
            end

            S_HALT:  state_d = S_HALT;

            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            acc_q   <= '0;
            ireg_q  <= '0;
            iar_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ireg_q  <= ireg_d;
            iar_q   <= iar_d;
        end
    end

    // Reset gates the bus so an in-flight access is never issued to memory.
    assign En          = mem_en & ~rst;
    assign Rw          = mem_rw;
    assign Address_Bus = En ? mem_addr : '0;
    assign Data_Bus    = (En && !Rw) ? acc_q : 'z;

    always_comb begin
        case (regSelect)
            2'd0:    dispReg = ireg_q;
            2'd1:    dispReg = pc_q;
            2'd2:    dispReg = acc_q;
            default: dispReg = iar_q;
        endcase
    end

endmodule

// File: tb/tb_very_half_sam_core.sv
// Bench for very_half_sam_core: instruction-level reference model predicting
// every bus cycle, directed scenarios with literal expectations, random programs.
module tb_very_half_sam_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] regSelect = 2'd0;
    logic       En, Rw;
    logic [7:0] Address_Bus, dispReg;
    wire  [7:0] Data_Bus;

    very_half_sam_core dut (
        .clk(clk), .rst(rst), .En(En), .Rw(Rw), .Address_Bus(Address_Bus),
        .Data_Bus(Data_Bus), .pause(pause), .regSelect(regSelect), .dispReg(dispReg)
    );

    always #5 clk = ~clk;

    // External synchronous memory.
    logic [7:0] img [0:255];
    logic [7:0] mem [0:255];
    logic       rd_drv = 1'b0;
    logic [7:0] rd_data = 8'h00;

    assign Data_Bus = rd_drv ? rd_data : 8'bz;

    always @(posedge clk) begin
        rd_drv <= 1'b0;
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (En) begin
            if (Rw) begin
                rd_drv  <= 1'b1;
                rd_data <= mem[Address_Bus];
            end else begin
                mem[Address_Bus] <= Data_Bus;
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state plus a queue of expected bus cycles.
    typedef struct packed {
        logic       en;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wd;
    } cyc_t;

    cyc_t       expq [$];
    logic [7:0] mm [0:255];
    logic [7:0] m_pc, m_acc, m_ireg, m_iar;
    logic       m_halt;
    logic [7:0] fetch_log [$];

    function automatic void push(input logic en, input logic rw, input logic [7:0] a, input logic [7:0] d);
        cyc_t c;
        c.en = en; c.rw = rw; c.addr = a; c.wd = d;
        expq.push_back(c);
    endfunction

    function automatic void rd(input logic [7:0] a);
        push(1'b1, 1'b1, a, 8'h00);
        push(1'b0, 1'b1, 8'h00, 8'h00);
    endfunction

    function automatic void issue();
        logic [7:0] ins, sx, xa;
        ins = mm[m_pc];
        rd(m_pc);
        m_pc   = m_pc + 8'd1;
        m_ireg = ins;
        xa     = {4'h0, ins[3:0]};
        sx     = {{4{ins[3]}}, ins[3:0]};
        case (ins[7:4])
            4'h0: if (ins[3:0] == 4'h1) m_acc = 8'd0 - m_acc; else m_halt = 1'b1;
            4'h1: m_pc = m_pc + sx;
            4'h2: if (m_acc == 8'd0) m_pc = m_pc + sx;
            4'h3: if ($signed(m_acc) > 8'sd0) m_pc = m_pc + sx;
            4'h4: if ($signed(m_acc) < 8'sd0) m_pc = m_pc + sx;
            4'h5: begin rd(xa); m_pc = mm[xa]; end
            4'h6: m_acc = sx;
            4'h7: begin rd(xa); m_acc = mm[xa]; end
            4'h8: begin rd(xa); m_iar = mm[xa]; rd(m_iar); m_acc = mm[m_iar]; end
            4'h9: push(1'b1, 1'b0, xa, m_acc);
            4'hA: begin rd(xa); m_iar = mm[xa]; push(1'b1, 1'b0, m_iar, m_acc); end
            4'hB: begin rd(xa); m_acc = m_acc + mm[xa]; end
            4'hC: begin rd(xa); m_acc = m_acc & mm[xa]; end
            default: m_halt = 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] model_reg(input logic [1:0] sel);
        case (sel)
            2'd0:    return m_ireg;
            2'd1:    return m_pc;
            2'd2:    return m_acc;
            default: return m_iar;
        endcase
    endfunction

    task automatic check_cycle();
        cyc_t c;
        c = expq.pop_front();
        check("bus_en", {7'd0, En}, {7'd0, c.en});
        if (c.en) begin
            check("bus_rw", {7'd0, Rw}, {7'd0, c.rw});
            check("bus_addr", Address_Bus, c.addr);
            if (!c.rw) begin
                check("bus_wdata", Data_Bus, c.wd);
                mm[c.addr] = c.wd;
            end
        end else begin
            check("idle_addr", Address_Bus, 8'h00);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (rst) begin
            expq.delete();
            m_pc = '0; m_acc = '0; m_ireg = '0; m_iar = '0; m_halt = 1'b0;
            if (load) for (int i = 0; i < 256; i++) mm[i] = img[i];
            check("rst_en", {7'd0, En}, 8'h00);
        end else if (expq.size() == 0) begin
            check("disp_reg", dispReg, model_reg(regSelect));
            if (m_halt || pause) begin
                check("idle_en", {7'd0, En}, 8'h00);
                check("idle_addr", Address_Bus, 8'h00);
            end else begin
                fetch_log.push_back(Address_Bus);
                issue();
                check_cycle();
            end
        end else begin
            check_cycle();
        end
    end

    task automatic do_reset(input logic reload);
        @(negedge clk);
        rst  = 1'b1;
        load = reload;
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    task automatic wait_fetch(input logic [7:0] a, output logic found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #2;
            if (En && Rw && Address_Bus == a) found = 1'b1;
        end
    endtask

    task automatic sweep_regs(input string name, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_v [0:3];
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
        for (int s = 0; s < 4; s++) begin
            regSelect = 2'(s);
            #1;
            check(name, dispReg, exp_v[s]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] cnt;
        logic       found;
        logic [3:0] op;
        int         ndiff;

        // Directed program: branch chain, data ops, branch conditions, halt.
        clear_img();
        img[8'h00] = 8'h17; img[8'h08] = 8'h17; img[8'h10] = 8'h12;
        img[8'h01] = 8'h61; img[8'h02] = 8'h01; img[8'h03] = 8'h02; img[8'h07] = 8'hFD;
        img[8'h0D] = 8'h80; img[8'h0E] = 8'hFF; img[8'h0F] = 8'h06;
        img[8'h13] = 8'h63; img[8'h14] = 8'hC1; img[8'h15] = 8'h94; img[8'h16] = 8'h82;
        img[8'h17] = 8'hB1; img[8'h18] = 8'hC3; img[8'h19] = 8'hAF; img[8'h1A] = 8'hBE;
        img[8'h1B] = 8'h95; img[8'h1C] = 8'h77; img[8'h1D] = 8'h01; img[8'h1E] = 8'h97;
        img[8'h1F] = 8'h60; img[8'h20] = 8'h21; img[8'h21] = 8'h00; img[8'h22] = 8'h7D;
        img[8'h23] = 8'h31; img[8'h24] = 8'h42; img[8'h25] = 8'h00; img[8'h26] = 8'h00;
        img[8'h27] = 8'h00;
        pause = 1'b1;
        regSelect = 2'd1;
        do_reset(1'b1);
        #2;
        check("reset_en", {7'd0, En}, 8'h00);
        sweep_regs("reset_reg", 8'h00, 8'h00, 8'h00, 8'h00);
        regSelect = 2'd1;
        fetch_log.delete();
        @(negedge clk);
        pause = 1'b0;
        repeat (80) @(negedge clk);
        cnt = 8'd0;
        repeat (20) begin
            @(negedge clk);
            #2;
            if (En) cnt++;
        end
        check("halt_no_en", cnt, 8'h00);
        sweep_regs("halt_regs", 8'h00, 8'h28, 8'h80, 8'h06);
        check("fetch_log_len", {7'd0, fetch_log.size() >= 4}, 8'h01);
        if (fetch_log.size() >= 4) begin
            check("pc_seq0", fetch_log[0], 8'h00);
            check("pc_seq1", fetch_log[1], 8'h08);
            check("pc_seq2", fetch_log[2], 8'h10);
            check("pc_seq3", fetch_log[3], 8'h13);
        end
        check("mem4", mem[4], 8'h01);
        check("mem5", mem[5], 8'h01);
        check("mem6", mem[6], 8'h02);
        check("mem7", mem[7], 8'h03);

        // Pause asserted during an add.
        clear_img();
        img[0] = 8'h65; img[1] = 8'hB9; img[2] = 8'h61; img[9] = 8'h10;
        regSelect = 2'd1;
        do_reset(1'b1);
        wait_fetch(8'h01, found);
        check("pause_wait_fetch", {7'd0, found}, 8'h01);
        @(negedge clk);
        pause = 1'b1;
        repeat (3) @(negedge clk);
        cnt = 8'd0;
        repeat (8) begin
            #2;
            if (En) cnt++;
            @(negedge clk);
        end
        check("pause_no_en", cnt, 8'h00);
        regSelect = 2'd2;
        #1;
        check("pause_acc", dispReg, 8'h15);
        regSelect = 2'd1;
        #1;
        check("pause_pc", dispReg, 8'h02);
        @(negedge clk);
        pause = 1'b0;
        #2;
        check("resume_fetch", {6'd0, En, Rw}, 8'h03);
        check("resume_addr", Address_Bus, 8'h02);
        repeat (10) @(negedge clk);

        // Reset during istore, before its write is issued.
        clear_img();
        img[0] = 8'h67; img[1] = 8'hAF; img[6] = 8'h55; img[8'h0F] = 8'h06;
        do_reset(1'b1);
        wait_fetch(8'h01, found);
        check("istore_wait_fetch", {7'd0, found}, 8'h01);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pause = 1'b1;
        #2;
        check("abort_no_write", mem[6], 8'h55);
        check("abort_en", {7'd0, En}, 8'h00);
        sweep_regs("abort_regs", 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        pause = 1'b0;
        #2;
        check("abort_refetch", {6'd0, En, Rw}, 8'h03);
        check("abort_refetch_addr", Address_Bus, 8'h00);
        repeat (20) @(negedge clk);

        // Random programs with random pause, display select and resets.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 256; i++) begin
                case ($urandom_range(0, 9))
                    8: img[i] = 8'h01;
                    9: img[i] = 8'($urandom);
                    default: begin
                        op = 4'($urandom_range(1, 12));
                        img[i] = {op, 4'($urandom)};
                    end
                endcase
            end
            pause = 1'b0;
            do_reset(1'b1);
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                pause     = ($urandom_range(0, 99) < 15);
                regSelect = 2'($urandom_range(0, 3));
                rst       = ($urandom_range(0, 99) < 2);
            end
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            #2;
            ndiff = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) ndiff++;
            check("mem_image", 8'(ndiff), 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
